i2c_reg_seq: RTL and testbench

- Sequences the single-master I2C byte engine (`i2c`) to perform complete single-byte register transactions for a host.
  - Write: START, addr+W, reg, data, STOP.
  - Read: START, addr+W, reg, RESTART, addr+R, read (master NACK), STOP.
- Sits between the host/CSR logic and `i2c`. Owns the `i2c` cmd/data_in/write inputs exclusively.
- Reports completion, read data and slave-NACK/timeout errors on a one-cycle response pulse.

---
 rtl/i2c_reg_seq.sv | 174 +++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - sequences the i2c byte engine through single-byte register write/read transactions
module i2c_reg_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [2:0]  CMD_START      = 3'd0,
    parameter logic [2:0]  CMD_RESTART    = 3'd1,
    parameter logic [2:0]  CMD_STOP       = 3'd2,
    parameter logic [2:0]  CMD_READ       = 3'd3,
    parameter logic [2:0]  CMD_WRITE      = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [2:0] m_cmd,
    output logic [7:0] m_data,
    output logic       m_write,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic [7:0] m_data_out,
    input  logic       m_ack
);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, ABORT, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  step, step_nxt;
    logic        aborting, aborting_nxt;
    logic [1:0]  err, err_nxt;
    logic [7:0]  rdata, rdata_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  cmd_q, cmd_nxt;
    logic [7:0]  dat_q, dat_nxt;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q, wdata_q;
    logic [2:0]  step_cmd;
    logic [7:0]  step_dat;
    logic        byte_cmd, step_done;

    // Command for the current step; an abort always substitutes a STOP.
    always_comb begin
        step_cmd = CMD_STOP;
        step_dat = 8'h00;
        if (!aborting) begin
            case (step)
                3'd0: step_cmd = CMD_START;
                3'd1: begin step_cmd = CMD_WRITE; step_dat = {dev_q, 1'b0}; end
                3'd2: begin step_cmd = CMD_WRITE; step_dat = reg_q; end
                3'd3: begin
                    if (rw_q) step_cmd = CMD_RESTART;
                    else begin step_cmd = CMD_WRITE; step_dat = wdata_q; end
                end
                3'd4: begin
                    if (rw_q) begin step_cmd = CMD_WRITE; step_dat = {dev_q, 1'b1}; end
                end
                3'd5: begin step_cmd = CMD_READ; step_dat = 8'h01; end
                default: step_cmd = CMD_STOP;
            endcase
        end
    end

    assign byte_cmd  = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
    assign step_done = byte_cmd ? m_done_tick : m_ready;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata;
    assign rsp_err   = err;
    assign m_write   = (state == ISSUE) && m_ready;
    assign m_cmd     = (state == ISSUE) ? step_cmd : cmd_q;
    assign m_data    = (state == ISSUE) ? step_dat : dat_q;

    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        aborting_nxt = aborting;
        err_nxt      = err;
        rdata_nxt    = rdata;
        cnt_nxt      = cnt;
        cmd_nxt      = cmd_q;
        dat_nxt      = dat_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt    = ISSUE;
                    step_nxt     = 3'd0;
                    aborting_nxt = 1'b0;
                    err_nxt      = 2'b00;
                    cnt_nxt      = '0;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    cmd_nxt   = step_cmd;
                    dat_nxt   = step_dat;
                    cnt_nxt   = '0;
                    state_nxt = ARM;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 2'b10;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ARM: state_nxt = WAIT;
            WAIT: begin
                // Completion is checked first so a done_tick beats a same-cycle timeout.
                if (step_done) begin
                    if (cmd_q == CMD_READ) rdata_nxt = m_data_out;
                    if (cmd_q == CMD_WRITE && m_ack) begin
                        err_nxt   = 2'b01;
                        state_nxt = ABORT;
                    end else if (cmd_q == CMD_STOP) begin
                        state_nxt = RESP;
                    end else begin
                        step_nxt  = step + 3'd1;
                        state_nxt = ISSUE;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 2'b10;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ABORT: begin
                aborting_nxt = 1'b1;
                state_nxt    = ISSUE;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= 3'd0;
            aborting <= 1'b0;
            err      <= 2'b00;
            rdata    <= 8'h00;
            cnt      <= '0;
            cmd_q    <= CMD_STOP;
            dat_q    <= 8'h00;
            rw_q     <= 1'b0;
            dev_q    <= 7'h00;
            reg_q    <= 8'h00;
            wdata_q  <= 8'h00;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            aborting <= aborting_nxt;
            err      <= err_nxt;
            rdata    <= rdata_nxt;
            cnt      <= cnt_nxt;
            cmd_q    <= cmd_nxt;
            dat_q    <= dat_nxt;
            if (state == IDLE && req_valid) begin
                rw_q    <= req_rw;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - bench for i2c_reg_seq with a 20-cycle master BFM and a command-list reference model
module tb_i2c_reg_seq;
    localparam logic [2:0] C_START = 3'd0, C_RESTART = 3'd1, C_STOP = 3'd2, C_READ = 3'd3, C_WRITE = 3'd4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic [2:0] m_cmd;
    logic [7:0] m_data;
    logic       m_write, m_ready, m_done_tick, m_ack;
    logic [7:0] m_data_out;

    always #5 clk = ~clk;

    i2c_reg_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_cmd(m_cmd), .m_data(m_data), .m_write(m_write),
        .m_ready(m_ready), .m_done_tick(m_done_tick), .m_data_out(m_data_out), .m_ack(m_ack)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master BFM: logs every strobe, finishes each command 20 cycles later.
    logic [2:0] log_cmd [0:1023];
    logic [7:0] log_dat [0:1023];
    int         log_cyc [0:1023];
    int         log_n = 0;
    int         nack_log_idx = -1;
    logic [7:0] bfm_rd = 8'h00;
    bit         bfm_hang = 1'b0;
    int         bfm_cnt, bfm_idx;
    logic [2:0] bfm_cmd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready <= 1'b1; m_done_tick <= 1'b0; m_ack <= 1'b0; m_data_out <= 8'h00;
            bfm_cnt <= 0; bfm_cmd <= C_STOP; bfm_idx <= 0;
        end else begin
            m_done_tick <= 1'b0;
            if (m_write) begin
                log_cmd[log_n] <= m_cmd; log_dat[log_n] <= m_data; log_cyc[log_n] <= cyc;
                bfm_idx <= log_n; log_n <= log_n + 1;
                m_ready <= 1'b0; bfm_cnt <= 20; bfm_cmd <= m_cmd;
            end else if (bfm_cnt == 1) begin
                if (!(bfm_hang && bfm_cmd == C_START)) begin
                    bfm_cnt <= 0;
                    m_ready <= 1'b1;
                    if (bfm_cmd == C_WRITE || bfm_cmd == C_READ) begin
                        m_done_tick <= 1'b1;
                        m_ack       <= (bfm_cmd == C_READ) || (bfm_idx == nack_log_idx);
                        m_data_out  <= (bfm_cmd == C_READ) ? bfm_rd : ~bfm_rd;
                    end
                end
            end else if (bfm_cnt > 1) begin
                bfm_cnt <= bfm_cnt - 1;
            end
        end
    end

    // Reference model: the command list a transaction should produce.
    logic [2:0] exp_cmd[$];
    logic [7:0] exp_dat[$];
    logic [7:0] exp_rdata = 8'h00;

    task automatic build_exp(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, input int nack_pos);
        exp_cmd.delete(); exp_dat.delete();
        exp_cmd.push_back(C_START); exp_dat.push_back(8'h00);
        exp_cmd.push_back(C_WRITE); exp_dat.push_back({dev, 1'b0});
        exp_cmd.push_back(C_WRITE); exp_dat.push_back(rg);
        if (rw) begin
            exp_cmd.push_back(C_RESTART); exp_dat.push_back(8'h00);
            exp_cmd.push_back(C_WRITE);   exp_dat.push_back({dev, 1'b1});
            exp_cmd.push_back(C_READ);    exp_dat.push_back(8'h01);
        end else begin
            exp_cmd.push_back(C_WRITE); exp_dat.push_back(wd);
        end
        exp_cmd.push_back(C_STOP); exp_dat.push_back(8'h00);
        if (nack_pos >= 0) begin
            while (exp_cmd.size() > nack_pos + 1) begin
                void'(exp_cmd.pop_back()); void'(exp_dat.pop_back());
            end
            exp_cmd.push_back(C_STOP); exp_dat.push_back(8'h00);
        end
    endtask

    function automatic int log_mismatches(input int start, input int n);
        int bad = 0;
        if (n != exp_cmd.size()) bad++;
        for (int i = 0; i < exp_cmd.size(); i++) begin
            if (log_cmd[start + i] !== exp_cmd[i]) bad++;
            else if ((exp_cmd[i] == C_WRITE || exp_cmd[i] == C_READ) && log_dat[start + i] !== exp_dat[i]) bad++;
        end
        return bad;
    endfunction

    task automatic run_txn(input string name, input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rd, input int nack_pos);
        int start, waited, bad;
        bit ready_seen;
        logic [1:0] exp_err;
        build_exp(rw, dev, rg, wd, nack_pos);
        exp_err = (nack_pos >= 0) ? 2'b01 : 2'b00;
        if (rw && nack_pos < 0) exp_rdata = rd;
        @(negedge clk);
        start = log_n;
        nack_log_idx = (nack_pos >= 0) ? start + nack_pos : -1;
        bfm_rd = rd;
        req_rw = rw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL %s idle_ready: got %b want 1", name, req_ready); end
        @(negedge clk);
        req_valid = 1'b0; req_rw = ~rw; req_dev = ~dev; req_reg = ~rg; req_wdata = ~wd;
        waited = 0; ready_seen = 1'b0;
        while (rsp_valid !== 1'b1 && waited < 3000) begin
            if (req_ready !== 1'b0) ready_seen = 1'b1;
            @(negedge clk); waited++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL %s rsp_seen: got none within %0d cycles want pulse", name, waited); end
        checks++;
        if (ready_seen) begin failures++; $display("FAIL %s ready_low: got req_ready=1 mid-transaction want 0", name); end
        checks++;
        if (rsp_err !== exp_err) begin failures++; $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, exp_err); end
        checks++;
        if (rsp_rdata !== exp_rdata) begin failures++; $display("FAIL %s rsp_rdata: got %h want %h", name, rsp_rdata, exp_rdata); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL %s one_pulse: got valid=%b ready=%b want 0/1", name, rsp_valid, req_ready);
        end
        bad = log_mismatches(start, log_n - start);
        checks++;
        if (bad != 0) begin failures++; $display("FAIL %s cmd_seq: got %0d cmds %0d mismatches want %0d cmds 0 mismatches", name, log_n - start, bad, exp_cmd.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || m_write !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl: got ready=%b valid=%b write=%b want 1/0/0", req_ready, rsp_valid, m_write);
        end
        checks++;
        if (rsp_rdata !== 8'h00 || rsp_err !== 2'b00 || m_cmd !== C_STOP || m_data !== 8'h00) begin
            failures++; $display("FAIL reset_data: got rdata=%h err=%b cmd=%0d data=%h want 00/00/2/00", rsp_rdata, rsp_err, m_cmd, m_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        run_txn("write", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h11, -1);
    endtask

    task automatic test_read();
        run_txn("read", 1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, -1);
    endtask

    task automatic test_addr_nack();
        run_txn("addr_nack", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h99, 1);
    endtask

    task automatic test_random();
        bit rw; int r, pos;
        for (int i = 0; i < 14; i++) begin
            rw  = 1'($urandom);
            r   = int'($urandom_range(0, 5));
            pos = (r < 3) ? ((rw && r == 2) ? 4 : r + 1) : -1;
            run_txn($sformatf("rand%0d", i), rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), pos);
        end
    endtask

    task automatic test_back_to_back();
        int start_a, start_b, waited;
        bit ready_seen;
        @(negedge clk);
        start_a = log_n; nack_log_idx = -1; bfm_rd = 8'h77;
        req_rw = 1'b0; req_dev = 7'h21; req_reg = 8'h05; req_wdata = 8'hC3; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b idle_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_rw = 1'b1; req_dev = 7'h22; req_reg = 8'h06; req_wdata = 8'h00;
        waited = 0; ready_seen = 1'b0;
        while (rsp_valid !== 1'b1 && waited < 3000) begin
            if (req_ready !== 1'b0) ready_seen = 1'b1;
            @(negedge clk); waited++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || ready_seen || req_ready !== 1'b0) begin
            failures++; $display("FAIL b2b first: got valid=%b ready_seen=%b ready=%b want 1/0/0", rsp_valid, ready_seen, req_ready);
        end
        checks++;
        if (rsp_err !== 2'b00) begin failures++; $display("FAIL b2b first_err: got %b want 00", rsp_err); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b second_accept: got ready=%b want 1", req_ready); end
        start_b = log_n;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0; ready_seen = 1'b0;
        while (rsp_valid !== 1'b1 && waited < 3000) begin
            if (req_ready !== 1'b0) ready_seen = 1'b1;
            @(negedge clk); waited++;
        end
        exp_rdata = 8'h77;
        checks++;
        if (rsp_valid !== 1'b1 || ready_seen) begin failures++; $display("FAIL b2b second: got valid=%b ready_seen=%b want 1/0", rsp_valid, ready_seen); end
        checks++;
        if (rsp_err !== 2'b00 || rsp_rdata !== exp_rdata) begin
            failures++; $display("FAIL b2b second_rsp: got err=%b rdata=%h want 00/%h", rsp_err, rsp_rdata, exp_rdata);
        end
        build_exp(1'b0, 7'h21, 8'h05, 8'hC3, -1);
        checks++;
        if (log_mismatches(start_a, start_b - start_a) != 0) begin failures++; $display("FAIL b2b seq_a: got %0d cmds want %0d", start_b - start_a, exp_cmd.size()); end
        build_exp(1'b1, 7'h22, 8'h06, 8'h00, -1);
        checks++;
        if (log_mismatches(start_b, log_n - start_b) != 0) begin failures++; $display("FAIL b2b seq_b: got %0d cmds want %0d", log_n - start_b, exp_cmd.size()); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int start, waited, exp_cyc;
        @(negedge clk);
        bfm_hang = 1'b1; nack_log_idx = -1; start = log_n;
        req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'hA5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; waited = 0;
        while (rsp_valid !== 1'b1 && waited < 500) begin @(negedge clk); waited++; end
        exp_cyc = log_cyc[start] + 2 + TO;
        checks++;
        if (rsp_valid !== 1'b1 || cyc != exp_cyc) begin
            failures++; $display("FAIL timeout_time: got valid=%b cycle=%0d want 1 at %0d", rsp_valid, cyc, exp_cyc);
        end
        checks++;
        if (rsp_err !== 2'b10 || rsp_rdata !== exp_rdata) begin
            failures++; $display("FAIL timeout_rsp: got err=%b rdata=%h want 10/%h", rsp_err, rsp_rdata, exp_rdata);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (log_n != start + 1) begin failures++; $display("FAIL timeout_no_stop: got %0d strobes want 1", log_n - start); end
    endtask

    task automatic test_reset_mid_read();
        int start, waited;
        @(negedge clk);
        reset = 1'b1; bfm_hang = 1'b0; exp_rdata = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        start = log_n; nack_log_idx = -1; bfm_rd = 8'hE7;
        req_rw = 1'b1; req_dev = 7'h33; req_reg = 8'h44; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; waited = 0;
        while (!(log_n > start && log_cmd[log_n - 1] == C_READ) && waited < 3000) begin @(negedge clk); waited++; end
        checks++;
        if (!(log_n > start && log_cmd[log_n - 1] == C_READ)) begin failures++; $display("FAIL rst_mid reach_read: got %0d strobes want READ issued", log_n - start); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (m_write !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || m_cmd !== C_STOP) begin
            failures++; $display("FAIL rst_mid outputs: got write=%b ready=%b valid=%b cmd=%0d want 0/1/0/2", m_write, req_ready, rsp_valid, m_cmd);
        end
        @(negedge clk);
        reset = 1'b0;
        run_txn("after_reset", 1'b0, 7'h50, 8'h10, 8'hA5, 8'h12, -1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
